// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pkg: shared timing helpers and 800x600@72 default constants   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package vga_pkg;

  localparam int VGA_H_VIS      = 800;
  localparam int VGA_H_FP       = 56;
  localparam int VGA_H_SYNC     = 120;
  localparam int VGA_H_BP       = 64;
  localparam int VGA_V_VIS      = 600;
  localparam int VGA_V_FP       = 37;
  localparam int VGA_V_SYNC     = 6;
  localparam int VGA_V_BP       = 23;
  localparam int VGA_WIN_X0     = 200;
  localparam int VGA_WIN_X1     = 603;
  localparam int VGA_SCALE_LOG2 = 2;
  localparam int VGA_RD_LAT     = 1;
  localparam int VGA_CW         = 2;
  localparam int VGA_WR_OFS     = 16;
  localparam int VGA_WR_LEN     = 101;

  // Channel position inside a packed {B,G,R} pixel word.
  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } rgb_chan_e;

  function automatic int timing_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_delay_line: ce-qualified shift register, depth 0 = passthrough |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d = stage_q;
        if (ce) begin
          stage_d[0] = d;
          for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_timing_gen: VGA sync/blanking, scaled framebuffer read address |
// | and blanking write slot, syncs re-aligned to read latency          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIS      = VGA_H_VIS,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_VIS      = VGA_V_VIS,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int WIN_X0     = VGA_WIN_X0,
  parameter int WIN_X1     = VGA_WIN_X1,
  parameter int SCALE_LOG2 = VGA_SCALE_LOG2,
  parameter int RD_LAT     = VGA_RD_LAT,
  parameter int CW         = VGA_CW,
  parameter int WR_OFS     = VGA_WR_OFS,
  parameter int WR_LEN     = VGA_WR_LEN,
  localparam int RXW       = cnt_w(H_VIS) - SCALE_LOG2,
  localparam int RYW       = cnt_w(V_VIS) - SCALE_LOG2,
  localparam int WXW       = cnt_w(WR_LEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [3*CW-1:0] pix_in,
  output logic [3*CW-1:0] rgb,
  output logic            hsync,
  output logic            vsync,
  output logic            rd_en,
  output logic [RXW-1:0]  rd_x,
  output logic [RYW-1:0]  rd_y,
  output logic            wr_en,
  output logic [WXW-1:0]  wr_x,
  output logic [RYW-1:0]  wr_y,
  output logic            frame_start,
  output logic            line_start
);

  localparam int H_TOT = timing_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = timing_total(V_VIS, V_FP, V_SYNC, V_BP);
  localparam int HW    = cnt_w(H_TOT);
  localparam int VW    = cnt_w(V_TOT);
  localparam int BW    = 1 + RXW + RYW + 1 + WXW + RYW + 1 + 1;

  generate
    if (WIN_X0 < 0 || WIN_X1 >= H_VIS || WIN_X0 > WIN_X1) begin : g_bad_window
      $fatal(1, "vga_timing_gen: display window must lie inside the visible line");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
      $fatal(1, "vga_timing_gen: every porch and sync width must be at least 1");
    end
    if (RD_LAT < 0) begin : g_bad_lat
      $fatal(1, "vga_timing_gen: RD_LAT must be non-negative");
    end
    if (WR_OFS < 0 || WR_LEN < 1 || WR_OFS + WR_LEN > H_FP + H_SYNC + H_BP) begin : g_bad_slot
      $fatal(1, "vga_timing_gen: write slot must fit inside horizontal blanking");
    end
    if (RXW < 1 || RYW < 1) begin : g_bad_scale
      $fatal(1, "vga_timing_gen: SCALE_LOG2 leaves no address bits");
    end
  endgenerate

  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (ce) begin
      if (x_q == HW'(H_TOT - 1)) begin
        x_d = '0;
        y_d = (y_q == VW'(V_TOT - 1)) ? '0 : y_q + VW'(1);
      end else begin
        x_d = x_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  logic           line_vis, vis, in_win, hs_act, vs_act, wr_win;
  logic [HW-1:0]  win_dx, slot_dx;
  logic [RXW-1:0] rd_x_c;
  logic [RYW-1:0] rd_y_c, wr_y_c;
  logic [WXW-1:0] wr_x_c;

  always_comb begin
    line_vis = y_q < VW'(V_VIS);
    vis      = line_vis && (x_q < HW'(H_VIS));
    in_win   = line_vis && (x_q >= HW'(WIN_X0)) && (x_q <= HW'(WIN_X1));
    hs_act   = (x_q >= HW'(H_VIS + H_FP)) && (x_q < HW'(H_VIS + H_FP + H_SYNC));
    vs_act   = (y_q >= VW'(V_VIS + V_FP)) && (y_q < VW'(V_VIS + V_FP + V_SYNC));
    wr_win   = line_vis && (x_q >= HW'(H_VIS + WR_OFS)) && (x_q < HW'(H_VIS + WR_OFS + WR_LEN));
    win_dx   = x_q - HW'(WIN_X0);
    slot_dx  = x_q - HW'(H_VIS + WR_OFS);
    // Addresses are held at zero outside their strobes so idle buses stay quiet.
    rd_x_c   = in_win ? RXW'(win_dx >> SCALE_LOG2) : '0;
    rd_y_c   = in_win ? RYW'(y_q >> SCALE_LOG2) : '0;
    wr_x_c   = wr_win ? WXW'(slot_dx) : '0;
    wr_y_c   = wr_win ? RYW'(y_q >> SCALE_LOG2) : '0;
  end

  logic [BW-1:0] ctl_next, ctl_out;

  assign ctl_next = {in_win, rd_x_c, rd_y_c, wr_win, wr_x_c, wr_y_c,
                     (x_q == '0) && (y_q == '0), (x_q == '0)};

  vga_delay_line #(.WIDTH(BW), .DEPTH(1)) u_ctl (
    .clk   (clk),
    .rst_n (rst),
    .ce    (ce),
    .d     (ctl_next),
    .q     (ctl_out)
  );

  assign {rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, frame_start, line_start} = ctl_out;

  // One register stage for the read strobe plus RD_LAT for the memory.
  logic [3:0] align_q;

  vga_delay_line #(.WIDTH(4), .DEPTH(1 + RD_LAT)) u_align (
    .clk   (clk),
    .rst_n (rst),
    .ce    (ce),
    .d     ({in_win, vis, hs_act, vs_act}),
    .q     (align_q)
  );

  assign rgb   = (align_q[3] && align_q[2]) ? pix_in : '0;
  assign hsync = align_q[1] ? HS_POL : ~HS_POL;
  assign vsync = align_q[0] ? VS_POL : ~VS_POL;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vga_timing_gen: small and default configurations against a      |
// | position-based model, plus literal timing checks                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_vga_timing_gen;

  // Small configuration
  localparam int SX0 = 2, SX1 = 5, SHT = 14, SFR = 98, SLAT = 2;
  // Default configuration
  localparam int DHT = 1040, DFR = 1040 * 666, DLAT = 1;

  logic clk = 1'b0;
  logic rst, ce;
  always #5 clk = ~clk;

  logic [5:0] s_pix, s_rgb;
  logic       s_hs, s_vs, s_rd, s_wr, s_fs, s_ls;
  logic [1:0] s_rdx, s_wrx;
  logic [0:0] s_rdy, s_wry;

  logic [5:0] d_pix, d_rgb;
  logic       d_hs, d_vs, d_rd, d_wr, d_fs, d_ls;
  logic [7:0] d_rdx, d_rdy, d_wry;
  logic [6:0] d_wrx;

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .WIN_X0(SX0), .WIN_X1(SX1),
    .SCALE_LOG2(1), .RD_LAT(SLAT), .CW(2), .WR_OFS(1), .WR_LEN(3)
  ) u_small (
    .clk(clk), .rst(rst), .ce(ce), .pix_in(s_pix), .rgb(s_rgb),
    .hsync(s_hs), .vsync(s_vs), .rd_en(s_rd), .rd_x(s_rdx), .rd_y(s_rdy),
    .wr_en(s_wr), .wr_x(s_wrx), .wr_y(s_wry),
    .frame_start(s_fs), .line_start(s_ls)
  );

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .ce(ce), .pix_in(d_pix), .rgb(d_rgb),
    .hsync(d_hs), .vsync(d_vs), .rd_en(d_rd), .rd_x(d_rdx), .rd_y(d_rdy),
    .wr_en(d_wr), .wr_x(d_wrx), .wr_y(d_wry),
    .frame_start(d_fs), .line_start(d_ls)
  );

  int total = 0;
  int bad   = 0;
  int n     = 0;     // ce-qualified edges since reset release
  int cyc   = 0;     // raw clock edges
  logic [5:0] cap, pipe0, pipe1;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s n=%0d got=%0d want=%0d", name, n, got, exp);
    end
  endtask

  task automatic check_small();
    int p, x, y, q, xa, ya;
    logic erd, ewr;
    logic [5:0] ergb;
    if (n == 0) begin
      cmp("s_rst_rd", {s_rd, s_rdx, s_rdy}, 0);
      cmp("s_rst_wr", {s_wr, s_wrx, s_wry}, 0);
      cmp("s_rst_pulses", {s_fs, s_ls}, 0);
    end else begin
      p = (n - 1) % SFR; x = p % SHT; y = p / SHT;
      erd = (y < 4) && (x >= SX0) && (x <= SX1);
      ewr = (y < 4) && (x >= 9) && (x <= 11);
      cmp("s_rd_en", s_rd, erd);
      if (erd) begin
        cmp("s_rd_x", s_rdx, (x - SX0) >> 1);
        cmp("s_rd_y", s_rdy, y >> 1);
      end
      cmp("s_wr_en", s_wr, ewr);
      if (ewr) begin
        cmp("s_wr_x", s_wrx, x - 9);
        cmp("s_wr_y", s_wry, y >> 1);
      end
      cmp("s_frame_start", s_fs, p == 0);
      cmp("s_line_start", s_ls, x == 0);
      cmp("s_overlap", s_rd & s_wr, 0);
    end
    if (n < 1 + SLAT) begin
      cmp("s_rst_syncs", {s_hs, s_vs}, 0);
      cmp("s_rst_rgb", s_rgb, 0);
    end else begin
      q = (n - 1 - SLAT) % SFR; xa = q % SHT; ya = q / SHT;
      ergb = ((ya < 4) && (xa >= SX0) && (xa <= SX1)) ?
             {3'b110, 1'(ya >> 1), 2'((xa - SX0) >> 1)} : 6'd0;
      cmp("s_hsync", s_hs, (xa >= 10) && (xa < 12));
      cmp("s_vsync", s_vs, ya == 5);
      cmp("s_rgb", s_rgb, ergb);
    end
  endtask

  task automatic check_def();
    int p, x, y, q, xa, ya;
    logic erd;
    if (n == 0) begin
      cmp("d_rst_out", {d_rd, d_rdx, d_wr, d_wrx, d_fs, d_ls}, 0);
    end else begin
      p = (n - 1) % DFR; x = p % DHT; y = p / DHT;
      erd = (y < 600) && (x >= 200) && (x <= 603);
      cmp("d_rd_en", d_rd, erd);
      if (erd) cmp("d_rd_x", d_rdx, (x - 200) >> 2);
      cmp("d_wr_en", d_wr, (y < 600) && (x >= 816) && (x < 917));
      cmp("d_line_start", d_ls, x == 0);
    end
    if (n < 1 + DLAT) begin
      cmp("d_rst_syncs", {d_hs, d_vs, d_rgb}, 0);
    end else begin
      q = (n - 1 - DLAT) % DFR; xa = q % DHT; ya = q / DHT;
      cmp("d_hsync", d_hs, (xa >= 856) && (xa < 976));
      cmp("d_vsync", d_vs, (ya >= 637) && (ya < 643));
      cmp("d_rgb", d_rgb, ((ya < 600) && (xa >= 200) && (xa <= 603)) ? 6'b101010 : 6'd0);
    end
  endtask

  // One clock: drive ce, advance the framebuffer echo on ce edges, sample at negedge.
  task automatic step(input logic ce_v);
    ce = ce_v;
    @(posedge clk);
    cyc++;
    if (ce_v && rst) begin
      n++;
      pipe1 = pipe0;
      pipe0 = cap;
    end
    #1 s_pix = pipe1;
    @(negedge clk);
    cap = {3'b110, s_rdy, s_rdx};
    check_small();
    check_def();
  endtask

  task automatic do_reset();
    ce = 1'b0; rst = 1'b0; n = 0;
    pipe0 = '0; pipe1 = '0; cap = '0; s_pix = '0;
    @(negedge clk);
    check_small();
    check_def();
    rst = 1'b1;
  endtask

  int hs_r1, hs_r2, hs_f1, fs_r1, fs_r2, vs_r1, vs_f1, rd_first, rdx_first, rdx_max, rd_cnt;
  logic phs, pfs, pvs, prd;

  initial begin
    rst = 1'b0; ce = 1'b0; s_pix = '0; d_pix = 6'b101010;
    pipe0 = '0; pipe1 = '0; cap = '0;
    @(negedge clk);
    do_reset();
    step(1'b0);
    step(1'b0);

    // ce=1: two full frames
    hs_r1 = -1; hs_r2 = -1; hs_f1 = -1; fs_r1 = -1; fs_r2 = -1; vs_r1 = -1; vs_f1 = -1;
    phs = 0; pfs = 0; pvs = 0;
    for (int i = 0; i < 2 * SFR + 6; i++) begin
      step(1'b1);
      if (s_hs && !phs) begin if (hs_r1 < 0) hs_r1 = n; else if (hs_r2 < 0) hs_r2 = n; end
      if (!s_hs && phs && hs_f1 < 0) hs_f1 = n;
      if (s_fs && !pfs) begin if (fs_r1 < 0) fs_r1 = n; else if (fs_r2 < 0) fs_r2 = n; end
      if (s_vs && !pvs && vs_r1 < 0) vs_r1 = n;
      if (!s_vs && pvs && vs_f1 < 0) vs_f1 = n;
      phs = s_hs; pfs = s_fs; pvs = s_vs;
      if (n == 5)  cmp("lit_rgb_x2_y0", s_rgb, 6'h30);
      if (n == 7)  cmp("lit_rgb_x4_y0", s_rgb, 6'h31);
      if (n == 9)  cmp("lit_rgb_x6_y0", s_rgb, 6'h00);
      if (n == 33) cmp("lit_rgb_x2_y2", s_rgb, 6'h34);
      if (n == 10) cmp("lit_wr_x9", {s_wr, s_wrx}, 3'b100);
      if (n == 12) cmp("lit_wr_x11", {s_wr, s_wrx}, 3'b110);
    end
    cmp("lit_hs_first", hs_r1, 13);
    cmp("lit_hs_width", hs_f1 - hs_r1, 2);
    cmp("lit_hs_period", hs_r2 - hs_r1, 14);
    cmp("lit_fs_first", fs_r1, 1);
    cmp("lit_fs_period", fs_r2 - fs_r1, 98);
    cmp("lit_vs_first", vs_r1, 73);
    cmp("lit_vs_width", vs_f1 - vs_r1, 14);

    // ce toggling 1-of-2: periods in clock cycles double
    do_reset();
    hs_r1 = -1; hs_r2 = -1; fs_r1 = -1; fs_r2 = -1; phs = 0; pfs = 0;
    cyc = 0;
    for (int i = 0; i < 4 * SFR + 10; i++) begin
      step(i % 2 == 0);
      if (s_hs && !phs) begin if (hs_r1 < 0) hs_r1 = cyc; else if (hs_r2 < 0) hs_r2 = cyc; end
      if (s_fs && !pfs) begin if (fs_r1 < 0) fs_r1 = cyc; else if (fs_r2 < 0) fs_r2 = cyc; end
      phs = s_hs; pfs = s_fs;
    end
    cmp("lit_half_hs_period", hs_r2 - hs_r1, 28);
    cmp("lit_half_fs_period", fs_r2 - fs_r1, 196);

    // asynchronous reset mid-line at x=6, y=2
    do_reset();
    while (n < 34) step(1'b1);
    #2 rst = 1'b0;
    n = 0; pipe0 = '0; pipe1 = '0; cap = '0; s_pix = '0;
    #1;
    cmp("lit_async_rst", {s_rd, s_wr, s_fs, s_ls, s_hs, s_vs, s_rgb}, 0);
    check_small();
    check_def();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    step(1'b1);
    cmp("lit_fs_after_rst", {s_fs, s_ls}, 2'b11);
    step(1'b1);
    cmp("lit_fs_one_pulse", s_fs, 0);

    // default 800x600@72 geometry over three lines
    do_reset();
    hs_r1 = -1; hs_r2 = -1; rd_first = -1; rdx_first = -1; rdx_max = 0; rd_cnt = 0;
    phs = 0; prd = 0;
    for (int i = 0; i < 3 * DHT + 10; i++) begin
      step(1'b1);
      if (d_hs && !phs) begin if (hs_r1 < 0) hs_r1 = n; else if (hs_r2 < 0) hs_r2 = n; end
      if (d_rd && !prd && rd_first < 0) begin rd_first = n; rdx_first = int'(d_rdx); end
      if (d_rd && int'(d_rdx) > rdx_max) rdx_max = int'(d_rdx);
      if (d_rd && n <= DHT) rd_cnt++;
      phs = d_hs; prd = d_rd;
    end
    cmp("lit_def_hs_first", hs_r1, 858);
    cmp("lit_def_hs_period", hs_r2 - hs_r1, 1040);
    cmp("lit_def_rd_first", rd_first, 201);
    cmp("lit_def_rdx_first", rdx_first, 0);
    cmp("lit_def_rdx_max", rdx_max, 100);
    cmp("lit_def_rd_count", rd_cnt, 404);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
